// File: rtl/keypad_pkg.sv
// Shared types and helpers for the hex keypad scanner.
package keypad_pkg;

    localparam int ROWS = 4;
    localparam int COLS = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } keypad_state_t;

    typedef logic [3:0] key_code_t;

    function automatic logic is_one_hot(input logic [COLS-1:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

    // Only meaningful when the argument is one-hot.
    function automatic logic [1:0] col_index(input logic [COLS-1:0] v);
        logic [1:0] idx;
        case (v)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/hex_keypad_sync2.sv
// Two-flop synchronizer; resets to all ones, the released level of the columns.
module sync2 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] q_r;

    // Synchronizer chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= {WIDTH{1'b1}};
            q_r    <= {WIDTH{1'b1}};
        end else begin
            meta_r <= d;
            q_r    <= meta_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/hex_keypad.sv
// 4x4 hex keypad scanner: row drive, debounced press/release, nibble shift register.
module hex_keypad
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    output logic [3:0]  row_select_out,
    input  logic [3:0]  col_sense_in,
    output logic        key_valid_out,
    output logic [3:0]  key_code_out,
    output logic [15:0] value_out,
    input  logic        clear_in
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] COUNT_DONE = CW'(DEBOUNCE_SCANS);

    logic [COLS-1:0] col_raw_s;
    logic [COLS-1:0] col_s;
    logic            sample_s;
    logic            one_hot_s;
    logic [1:0]      col_idx_s;

    keypad_state_t   state_r, state_nxt_s;
    logic [DW-1:0]   dwell_r;
    logic [1:0]      row_r, row_nxt_s;
    logic [1:0]      col_r;
    logic [CW-1:0]   match_r, match_nxt_s;
    logic [CW-1:0]   release_r, release_nxt_s;
    logic            advance_s, latch_s, report_s;
    key_code_t       report_code_s;

    logic [3:0]      row_sel_r, row_sel_nxt_s;
    logic            key_valid_r;
    key_code_t       key_code_r, key_code_nxt_s;
    logic [15:0]     value_r, value_nxt_s;

    sync2 #(.WIDTH(COLS)) u_sync (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .d     (col_sense_in),
        .q     (col_raw_s)
    );

    assign col_s     = ~col_raw_s;
    assign sample_s  = (dwell_r == DWELL_LAST);
    assign one_hot_s = is_one_hot(col_s);
    assign col_idx_s = col_index(col_s);

    // State, dwell counter, scan row and debounce counters.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r   <= SCAN;
            dwell_r   <= {DW{1'b0}};
            row_r     <= 2'd0;
            col_r     <= 2'd0;
            match_r   <= {CW{1'b0}};
            release_r <= {CW{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            dwell_r   <= sample_s ? {DW{1'b0}} : dwell_r + DW'(1);
            row_r     <= row_nxt_s;
            col_r     <= latch_s ? col_idx_s : col_r;
            match_r   <= match_nxt_s;
            release_r <= release_nxt_s;
        end
    end

    // Next-state and counter decisions, evaluated only at sample points.
    always_comb begin
        state_nxt_s   = state_r;
        match_nxt_s   = match_r;
        release_nxt_s = release_r;
        advance_s     = 1'b0;
        latch_s       = 1'b0;
        report_s      = 1'b0;
        if (sample_s) begin
            case (state_r)
                SCAN: begin
                    if (one_hot_s) begin
                        latch_s     = 1'b1;
                        match_nxt_s = CW'(1);
                        if (COUNT_DONE == CW'(1)) begin
                            report_s      = 1'b1;
                            release_nxt_s = {CW{1'b0}};
                            state_nxt_s   = HELD;
                        end else begin
                            state_nxt_s   = DEBOUNCE;
                        end
                    end else begin
                        advance_s = 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (one_hot_s && (col_idx_s == col_r)) begin
                        match_nxt_s = match_r + CW'(1);
                        if ((match_r + CW'(1)) == COUNT_DONE) begin
                            report_s      = 1'b1;
                            release_nxt_s = {CW{1'b0}};
                            state_nxt_s   = HELD;
                        end else begin
                            state_nxt_s   = DEBOUNCE;
                        end
                    end else begin
                        advance_s   = 1'b1;
                        state_nxt_s = SCAN;
                    end
                end
                HELD: begin
                    if (col_s == 4'b0000) begin
                        if ((release_r + CW'(1)) == COUNT_DONE) begin
                            release_nxt_s = {CW{1'b0}};
                            advance_s     = 1'b1;
                            state_nxt_s   = SCAN;
                        end else begin
                            release_nxt_s = release_r + CW'(1);
                        end
                    end else begin
                        release_nxt_s = {CW{1'b0}};
                    end
                end
                default: begin
                    state_nxt_s = SCAN;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Next values of row drive and report outputs; clear wins over the shift.
    always_comb begin
        row_nxt_s      = advance_s ? row_r + 2'd1 : row_r;
        row_sel_nxt_s  = ~(4'b0001 << row_nxt_s);
        report_code_s  = latch_s ? {row_r, col_idx_s} : {row_r, col_r};
        key_code_nxt_s = key_code_r;
        value_nxt_s    = value_r;
        if (report_s) begin
            key_code_nxt_s = report_code_s;
        end else begin
            key_code_nxt_s = key_code_r;
        end
        if (clear_in) begin
            value_nxt_s = 16'h0000;
        end else if (report_s) begin
            value_nxt_s = {value_r[11:0], report_code_s};
        end else begin
            value_nxt_s = value_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            row_sel_r   <= 4'b1110;
            key_valid_r <= 1'b0;
            key_code_r  <= 4'h0;
            value_r     <= 16'h0000;
        end else begin
            row_sel_r   <= row_sel_nxt_s;
            key_valid_r <= report_s;
            key_code_r  <= key_code_nxt_s;
            value_r     <= value_nxt_s;
        end
    end

    assign row_select_out = row_sel_r;
    assign key_valid_out  = key_valid_r;
    assign key_code_out   = key_code_r;
    assign value_out      = value_r;

endmodule

// File: tb/tb_hex_keypad.sv
// Directed bench for hex_keypad with a matrix model that pulls a column low while its row is driven.
module tb_hex_keypad;

    logic        clk;
    logic        rst_n;
    logic [3:0]  row_select;
    logic [3:0]  col_sense;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] value;
    logic        clear;
    logic [15:0] keys;

    int passed = 0;
    int total  = 0;
    int pulses = 0;

    typedef struct {
        int          row;
        int          col;
        logic [3:0]  code;
        logic [15:0] value;
    } press_t;

    press_t vec[5];

    hex_keypad #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .row_select_out (row_select),
        .col_sense_in   (col_sense),
        .key_valid_out  (key_valid),
        .key_code_out   (key_code),
        .value_out      (value),
        .clear_in       (clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: a pressed key shorts its column to the driven (low) row.
    always_comb begin
        col_sense = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !row_select[r]) col_sense[c] = 1'b0;
            end
        end
    end

    always @(negedge clk) if (key_valid) pulses++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic wait_pulse(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (key_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, {31'd0, ok}, 32'd1);
    endtask

    task automatic align_row0();
        bit          found = 1'b0;
        logic [3:0]  prev  = row_select;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (row_select == 4'b1110 && prev != 4'b1110) begin
                found = 1'b1;
                break;
            end
            prev = row_select;
        end
        check("align_row0", {31'd0, found}, 32'd1);
    endtask

    task automatic press_and_release(input press_t p);
        int p0 = pulses;
        keys[p.row*4+p.col] = 1'b1;
        wait_pulse("press_pulse");
        check("press_code", {28'd0, key_code}, {28'd0, p.code});
        check("press_value", {16'd0, value}, {16'd0, p.value});
        @(negedge clk);
        check("pulse_width", {31'd0, key_valid}, 32'd0);
        repeat (20) @(negedge clk);
        keys = 16'h0000;
        repeat (40) @(negedge clk);
        check("one_pulse_per_press", pulses - p0, 32'd1);
    endtask

    initial begin
        int         p0;
        logic [3:0] exp_row;

        vec[0] = '{1, 2, 4'h6, 16'h0006};
        vec[1] = '{0, 1, 4'h1, 16'h0061};
        vec[2] = '{0, 2, 4'h2, 16'h0612};
        vec[3] = '{0, 3, 4'h3, 16'h6123};
        vec[4] = '{1, 0, 4'h4, 16'h1234};

        keys  = 16'h0000;
        clear = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_row", {28'd0, row_select}, {28'd0, 4'b1110});
        check("reset_valid", {31'd0, key_valid}, 32'd0);
        check("reset_code", {28'd0, key_code}, 32'd0);
        check("reset_value", {16'd0, value}, 32'd0);
        rst_n = 1'b1;

        // Idle scan: each row held for 4 cycles, no reports.
        for (int i = 0; i < 40; i++) begin
            exp_row = ~(4'b0001 << ((i / 4) % 4));
            check("idle_row", {28'd0, row_select}, {28'd0, exp_row});
            check("idle_valid", {31'd0, key_valid}, 32'd0);
            @(negedge clk);
        end

        for (int i = 0; i < 5; i++) press_and_release(vec[i]);

        // Bounce: two matching samples then release; row stays frozen, then advances.
        align_row0();
        p0 = pulses;
        keys[0] = 1'b1;
        repeat (5) @(negedge clk);
        check("bounce_frozen", {28'd0, row_select}, {28'd0, 4'b1110});
        repeat (3) @(negedge clk);
        keys = 16'h0000;
        repeat (4) @(negedge clk);
        check("bounce_next_row", {28'd0, row_select}, {28'd0, 4'b1101});
        repeat (4) @(negedge clk);
        check("bounce_scanning", {28'd0, row_select}, {28'd0, 4'b1011});
        repeat (20) @(negedge clk);
        check("bounce_no_pulse", pulses - p0, 32'd0);

        // Second column pressed while held, partial release, then full release.
        p0 = pulses;
        keys[9] = 1'b1;
        wait_pulse("held_pulse");
        check("held_code", {28'd0, key_code}, {28'd0, 4'h9});
        check("held_value", {16'd0, value}, {16'd0, 16'h2349});
        keys[11] = 1'b1;
        repeat (40) @(negedge clk);
        keys[9] = 1'b0;
        repeat (40) @(negedge clk);
        check("held_second_col", pulses - p0, 32'd1);
        keys[11] = 1'b0;
        repeat (6) @(negedge clk);
        keys[11] = 1'b1;
        repeat (40) @(negedge clk);
        keys = 16'h0000;
        repeat (40) @(negedge clk);
        check("held_full_release", pulses - p0, 32'd1);
        press_and_release('{3, 0, 4'hC, 16'h349C});

        // Two columns of one row together.
        p0 = pulses;
        keys[4] = 1'b1;
        keys[7] = 1'b1;
        repeat (80) @(negedge clk);
        keys = 16'h0000;
        repeat (40) @(negedge clk);
        check("multi_key", pulses - p0, 32'd0);

        // Reset asserted mid-debounce, key re-detected once afterwards.
        align_row0();
        keys[1] = 1'b1;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_async_row", {28'd0, row_select}, {28'd0, 4'b1110});
        check("rst_async_valid", {31'd0, key_valid}, 32'd0);
        check("rst_async_code", {28'd0, key_code}, 32'd0);
        check("rst_async_value", {16'd0, value}, 32'd0);
        @(negedge clk);
        p0 = pulses;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("rst_redetect_pulses", pulses - p0, 32'd1);
        check("rst_redetect_code", {28'd0, key_code}, {28'd0, 4'h1});
        check("rst_redetect_value", {16'd0, value}, {16'd0, 16'h0001});
        keys = 16'h0000;
        repeat (40) @(negedge clk);

        // Clear on the same edge as a report.
        align_row0();
        keys[2] = 1'b1;
        repeat (11) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_valid", {31'd0, key_valid}, 32'd1);
        check("clear_code", {28'd0, key_code}, {28'd0, 4'h2});
        check("clear_value", {16'd0, value}, 32'd0);
        @(negedge clk);
        check("clear_pulse_width", {31'd0, key_valid}, 32'd0);
        keys = 16'h0000;
        repeat (40) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
